// File: rtl/sata_tl_pkg.sv
// Shared definitions for the SATA transport-layer receive path.
// Contents: FIS type codes, tuser bit positions ({drop,err,keep[3:0],sop,eop}),
// the H2D register command struct, and the receive parser state encoding.
package sata_tl_pkg;

  localparam logic [7:0] FIS_REG_H2D = 8'h27;
  localparam logic [7:0] FIS_DATA    = 8'h46;
  localparam logic [7:0] FIS_BIST    = 8'h58;
  localparam logic [7:0] FIS_REG_D2H = 8'h34;  // transmit-only type

  localparam int TU_EOP     = 0;
  localparam int TU_SOP     = 1;
  localparam int TU_KEEP_LO = 2;
  localparam int TU_KEEP_HI = 5;
  localparam int TU_ERR     = 6;
  localparam int TU_DROP    = 7;

  typedef struct packed {
    logic        c;
    logic [7:0]  command;
    logic [15:0] features;
    logic [47:0] lba;
    logic [7:0]  device;
    logic [15:0] count;
    logic [7:0]  control;
  } h2d_reg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG,
    ST_DATA,
    ST_BIST,
    ST_DISCARD,
    ST_RESP
  } rx_state_e;

endpackage

// File: rtl/sata_axis_reg_slice.sv
// One-entry AXI-Stream register slice.
// Ports: clk/rst (async active-high); in_data_i/in_valid_i/in_ready_o upstream;
// out_data_o/out_valid_o/out_ready_i downstream. Full throughput when the
// consumer keeps ready high; reset empties the entry.
module sata_axis_reg_slice #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] data_q;
  logic         vld_q;

  assign in_ready_o  = !vld_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (in_ready_o) begin
      vld_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/sata_tl_rx_fis_dev.sv
// Device-side transport-layer receive parser.
// Classifies each received FIS (REG H2D, DATA, BIST, anything else discarded),
// unpacks REG FIS fields onto the cmd_* bus, forwards DATA payload (header
// stripped) through a one-entry output slice, and reports each frame's verdict
// with a one-cycle tl_ok/tl_err pulse the cycle after its eop handshake.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   s_axis_*           received FIS dwords, tuser {drop,err,keep[3:0],sop,eop}
//   tl_ok, tl_err      frame verdict pulses
//   cmd_vld, cmd_*     REG FIS fields; cmd_* hold until the next accepted REG FIS
//   m_axis_*           DATA payload; tuser err set on a failed frame's eop beat
// Optional: define SATA_TL_RX_STAT_EN to add saturating stat_ok_cnt,
// stat_err_cnt and stat_drop_cnt outputs.
module sata_tl_rx_fis_dev
  import sata_tl_pkg::*;
#(
  parameter int USER_W      = 8,
  parameter int MAX_DATA_DW = 2048,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_axis_tdata,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              tl_ok,
  output logic              tl_err,
  output logic              cmd_vld,
  output logic              cmd_c,
  output logic [7:0]        cmd_command,
  output logic [15:0]       cmd_features,
  output logic [47:0]       cmd_lba,
  output logic [7:0]        cmd_device,
  output logic [15:0]       cmd_count,
  output logic [7:0]        cmd_control,
  output logic [31:0]       m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
`ifdef SATA_TL_RX_STAT_EN
  ,
  output logic [CNT_W-1:0]  stat_ok_cnt,
  output logic [CNT_W-1:0]  stat_err_cnt,
  output logic [CNT_W-1:0]  stat_drop_cnt
`endif
);

  localparam int             PW   = $clog2(MAX_DATA_DW + 2);
  localparam logic [PW-1:0]  PMAX = PW'(MAX_DATA_DW);

  rx_state_e         st_q, st_d;
  logic [2:0]        idx_q, idx_d;     // dword index within REG/BIST frame
  logic [PW-1:0]     pcnt_q, pcnt_d;   // payload dwords forwarded so far
  logic              err_q, err_d;     // sticky frame error
  logic              rok_q, rok_d;     // verdict shown in RESP
  logic              rreg_q, rreg_d;   // frame was a REG FIS
  h2d_reg_t          sh_q, sh_d, cmd_q, cmd_d;

  logic              hs, b_sop, b_eop, b_err, beat_err, reg_last, over;
  logic [7:0]        fis_type;
  logic              sl_in_rdy, sl_push;
  logic [USER_W-1:0] sl_user;
  logic [31+USER_W:0] sl_out;

  assign b_sop    = s_axis_tuser[TU_SOP];
  assign b_eop    = s_axis_tuser[TU_EOP];
  assign b_err    = s_axis_tuser[TU_ERR] | s_axis_tuser[TU_DROP];
  assign fis_type = s_axis_tdata[7:0];

  // Held low through reset and during the one-cycle RESP gap.
  assign s_axis_tready = !rst && ((st_q == ST_DATA) ? sl_in_rdy : (st_q != ST_RESP));
  assign hs            = s_axis_tvalid && s_axis_tready;

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
    rok_d   = rok_q;
    rreg_d  = rreg_q;
    sh_d    = sh_q;
    cmd_d   = cmd_q;
    sl_push = 1'b0;
    sl_user = '0;
    // A sop inside a frame is data, but it still marks the frame bad.
    beat_err = err_q | b_err | (b_sop && (st_q != ST_IDLE));
    reg_last = (st_q == ST_BIST) ? (idx_q == 3'd2) : (idx_q == 3'd4);
    over     = (pcnt_q == PMAX);
    case (st_q)
      ST_IDLE: begin
        if (hs && b_sop) begin
          err_d  = b_err;
          idx_d  = 3'd1;
          pcnt_d = '0;
          rok_d  = 1'b0;
          rreg_d = (fis_type == FIS_REG_H2D);
          sh_d.c              = s_axis_tdata[15];
          sh_d.command        = s_axis_tdata[23:16];
          sh_d.features[7:0]  = s_axis_tdata[31:24];
          // Any single-dword frame is bad, including a zero-length DATA FIS.
          if (b_eop) st_d = ST_RESP;
          else begin
            case (fis_type)
              FIS_REG_H2D: st_d = ST_REG;
              FIS_DATA:    st_d = ST_DATA;
              FIS_BIST:    st_d = ST_BIST;
              default: begin
                err_d = 1'b1;
                st_d  = ST_DISCARD;
              end
            endcase
          end
        end
      end
      ST_REG, ST_BIST: begin
        if (hs) begin
          if (st_q == ST_REG) begin
            case (idx_q)
              3'd1: begin
                sh_d.lba[23:0] = s_axis_tdata[23:0];
                sh_d.device    = s_axis_tdata[31:24];
              end
              3'd2: begin
                sh_d.lba[47:24]     = s_axis_tdata[23:0];
                sh_d.features[15:8] = s_axis_tdata[31:24];
              end
              3'd3: begin
                sh_d.count   = s_axis_tdata[15:0];
                sh_d.control = s_axis_tdata[31:24];
              end
              default: ;
            endcase
          end
          err_d = beat_err;
          if (b_eop) begin
            st_d  = ST_RESP;
            rok_d = reg_last && !beat_err;
            // cmd_* switch at the eop edge so they are valid alongside cmd_vld.
            if ((st_q == ST_REG) && reg_last && !beat_err) cmd_d = sh_d;
          end else if (reg_last) begin
            err_d = 1'b1;
            st_d  = ST_DISCARD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          // Payload dword MAX_DATA_DW+1 is forwarded as a forced, errored eop.
          sl_push = 1'b1;
          sl_user[TU_SOP]                   = (pcnt_q == '0);
          sl_user[TU_EOP]                   = b_eop | over;
          sl_user[TU_KEEP_HI:TU_KEEP_LO]    = s_axis_tuser[TU_KEEP_HI:TU_KEEP_LO];
          sl_user[TU_ERR]                   = (b_eop | over) & (beat_err | over);
          pcnt_d = pcnt_q + 1'b1;
          err_d  = beat_err | over;
          if (b_eop) begin
            st_d  = ST_RESP;
            rok_d = !(beat_err | over);
          end else if (over) begin
            st_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (hs && b_eop) begin
          st_d  = ST_RESP;
          rok_d = 1'b0;
        end
      end
      ST_RESP: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      idx_q  <= '0;
      pcnt_q <= '0;
      err_q  <= 1'b0;
      rok_q  <= 1'b0;
      rreg_q <= 1'b0;
      sh_q   <= '0;
      cmd_q  <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      pcnt_q <= pcnt_d;
      err_q  <= err_d;
      rok_q  <= rok_d;
      rreg_q <= rreg_d;
      sh_q   <= sh_d;
      cmd_q  <= cmd_d;
    end
  end

  assign tl_ok   = (st_q == ST_RESP) && rok_q;
  assign tl_err  = (st_q == ST_RESP) && !rok_q;
  assign cmd_vld = tl_ok && rreg_q;

  assign cmd_c        = cmd_q.c;
  assign cmd_command  = cmd_q.command;
  assign cmd_features = cmd_q.features;
  assign cmd_lba      = cmd_q.lba;
  assign cmd_device   = cmd_q.device;
  assign cmd_count    = cmd_q.count;
  assign cmd_control  = cmd_q.control;

  sata_axis_reg_slice #(.W(32 + USER_W)) u_slice (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   ({sl_user, s_axis_tdata}),
    .in_valid_i  (sl_push),
    .in_ready_o  (sl_in_rdy),
    .out_data_o  (sl_out),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready)
  );

  assign m_axis_tdata = sl_out[31:0];
  assign m_axis_tuser = sl_out[31+USER_W:32];

`ifdef SATA_TL_RX_STAT_EN
  logic [CNT_W-1:0] ok_cnt_q, err_cnt_q, drop_cnt_q;
  logic             drop_beat;

  assign drop_beat = hs && (st_q == ST_IDLE) && !b_sop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (tl_ok && (ok_cnt_q != '1))       ok_cnt_q   <= ok_cnt_q + 1'b1;
      if (tl_err && (err_cnt_q != '1))     err_cnt_q  <= err_cnt_q + 1'b1;
      if (drop_beat && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign stat_ok_cnt   = ok_cnt_q;
  assign stat_err_cnt  = err_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sata_tl_rx_fis_dev.sv
// Self-checking bench for sata_tl_rx_fis_dev: directed frames followed by
// randomized frames, each checked against a frame-level reference model.
module tb_sata_tl_rx_fis_dev;
  import sata_tl_pkg::*;

  localparam int USER_W = 8;
  localparam int MAXD   = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       s_axis_tdata = '0;
  logic [USER_W-1:0] s_axis_tuser = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              tl_ok, tl_err, cmd_vld, cmd_c;
  logic [7:0]        cmd_command, cmd_device, cmd_control;
  logic [15:0]       cmd_features, cmd_count;
  logic [47:0]       cmd_lba;
  logic [31:0]       m_axis_tdata;
  logic [USER_W-1:0] m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;

  always #5 clk = ~clk;

  sata_tl_rx_fis_dev #(.USER_W(USER_W), .MAX_DATA_DW(MAXD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .tl_ok(tl_ok), .tl_err(tl_err), .cmd_vld(cmd_vld), .cmd_c(cmd_c),
    .cmd_command(cmd_command), .cmd_features(cmd_features), .cmd_lba(cmd_lba),
    .cmd_device(cmd_device), .cmd_count(cmd_count), .cmd_control(cmd_control),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  logic [104:0] cmd_bus;
  assign cmd_bus = {cmd_c, cmd_command, cmd_features, cmd_lba, cmd_device, cmd_count, cmd_control};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame under test
  logic [31:0] f_dw[$];
  logic [1:0]  f_eb[$];   // {drop,err}
  logic [3:0]  f_keep[$];
  logic        f_sop[$];
  int          send_limit = 1 << 30;
  logic        tmo = 1'b0;
  int          eop_cyc = 0;

  // model expectations
  logic [31:0] exp_dw[$];
  logic [7:0]  exp_us[$];
  logic        exp_ok, exp_reg, exp_resp;
  h2d_reg_t    m_cmd = '0;

  // observed
  logic [31:0]  o_dw[$];
  logic [7:0]   o_us[$];
  int           n_ok = 0, n_err = 0, n_vld = 0, n_both = 0, n_badvld = 0, resp_cyc = 0;
  logic [104:0] vld_cmd = '0;

  int rdy_mode = 0;
  always begin
    @(posedge clk); #2;
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        o_dw.push_back(m_axis_tdata);
        o_us.push_back(m_axis_tuser);
      end
      if (tl_ok && tl_err) n_both++;
      if (tl_ok) n_ok++;
      if (tl_err) n_err++;
      if (tl_ok || tl_err) resp_cyc = cyc;
      if (cmd_vld) begin n_vld++; vld_cmd = cmd_bus; end
      if (cmd_vld && !tl_ok) n_badvld++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_frame();
    f_dw.delete(); f_eb.delete(); f_keep.delete(); f_sop.delete();
  endtask

  task automatic add(input logic [31:0] d, input logic [1:0] eb = 2'b00, input logic sop = 1'b0);
    f_dw.push_back(d); f_eb.push_back(eb); f_sop.push_back(sop);
    f_keep.push_back(4'($urandom));
  endtask

  task automatic send_frame();
    int n, b;
    logic done;
    n = f_dw.size();
    if (n > send_limit) n = send_limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = f_dw[i];
      s_axis_tuser  = {f_eb[i], f_keep[i], f_sop[i], 1'(i == f_dw.size() - 1)};
      done = 1'b0; b = 0;
      while (!done) begin
        #1;
        if (s_axis_tready) begin
          done = 1'b1;
          if (i == f_dw.size() - 1) eop_cyc = cyc;
        end else if (b > 300) begin
          tmo = 1'b1; done = 1'b1;
        end
        @(posedge clk);
        if (!done) begin @(negedge clk); b++; end
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = '0;
  endtask

  // Frame-level reference: verdict, forwarded beats and command fields.
  task automatic model();
    int n, p, fwd;
    logic anyerr;
    logic [7:0] ty;
    n  = f_dw.size();
    ty = f_dw[0][7:0];
    exp_dw.delete(); exp_us.delete();
    exp_ok = 1'b0; exp_reg = 1'b0;
    exp_resp = f_sop[0];
    anyerr = 1'b0;
    for (int i = 0; i < n; i++) if (f_eb[i] != 2'b00 || (i > 0 && f_sop[i])) anyerr = 1'b1;
    if (!exp_resp) return;
    exp_reg = (ty == 8'h27);
    if (n == 1) exp_ok = 1'b0;
    else if (ty == 8'h27) begin
      exp_ok = (n == 5) && !anyerr;
      if (exp_ok) begin
        m_cmd.c        = f_dw[0][15];
        m_cmd.command  = f_dw[0][23:16];
        m_cmd.features = {f_dw[2][31:24], f_dw[0][31:24]};
        m_cmd.lba      = {f_dw[2][23:0], f_dw[1][23:0]};
        m_cmd.device   = f_dw[1][31:24];
        m_cmd.count    = f_dw[3][15:0];
        m_cmd.control  = f_dw[3][31:24];
      end
    end else if (ty == 8'h58) exp_ok = (n == 3) && !anyerr;
    else if (ty == 8'h46) begin
      p   = n - 1;
      fwd = (p > MAXD) ? MAXD + 1 : p;
      for (int k = 1; k <= fwd; k++) begin
        exp_dw.push_back(f_dw[k]);
        exp_us.push_back({1'b0, 1'((k == fwd) && (anyerr || p > MAXD)), f_keep[k],
                          1'(k == 1), 1'(k == fwd)});
      end
      exp_ok = !anyerr && (p <= MAXD);
    end
  endtask

  task automatic run_frame(input string tag);
    int r0, ok0, v0, t;
    r0 = n_ok + n_err; ok0 = n_ok; v0 = n_vld;
    model();
    o_dw.delete(); o_us.delete();
    send_frame();
    t = 0;
    while (exp_resp && (n_ok + n_err) == r0 && t < 200) begin @(negedge clk); t++; end
    t = 0;
    while (o_dw.size() < exp_dw.size() && t < 200) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk({tag, "_tmo"}, tmo, 1'b0);
    chk({tag, "_nresp"}, n_ok + n_err - r0, exp_resp ? 1 : 0);
    chk({tag, "_ok"}, n_ok - ok0, (exp_resp && exp_ok) ? 1 : 0);
    chk({tag, "_vld"}, n_vld - v0, (exp_ok && exp_reg) ? 1 : 0);
    if (exp_resp) chk({tag, "_lat"}, resp_cyc, eop_cyc + 1);
    if (exp_ok && exp_reg) chk({tag, "_vldcmd"}, vld_cmd, m_cmd);
    chk({tag, "_cmd"}, cmd_bus, m_cmd);
    chk({tag, "_nbeats"}, o_dw.size(), exp_dw.size());
    for (int k = 0; k < exp_dw.size(); k++) begin
      if (k < o_dw.size()) begin
        chk({tag, "_data"}, o_dw[k], exp_dw[k]);
        chk({tag, "_user"}, o_us[k], exp_us[k]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    #12;
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_ok", tl_ok, 1'b0);
    chk("rst_err", tl_err, 1'b0);
    chk("rst_vld", cmd_vld, 1'b0);
    chk("rst_mvld", m_axis_tvalid, 1'b0);
    chk("rst_cmd", cmd_bus, 105'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", s_axis_tready, 1'b1);

    // REG FIS accepted
    rdy_mode = 0;
    new_frame(); add(32'h00EC8027, 2'b00, 1'b1); add(32'hE0000000); add(32'h0); add(32'h1); add(32'h0);
    run_frame("reg_ok");
    chk("reg_c", cmd_c, 1'b1);
    chk("reg_command", cmd_command, 8'hEC);
    chk("reg_device", cmd_device, 8'hE0);
    chk("reg_count", cmd_count, 16'd1);

    // DATA FIS with toggling output ready
    rdy_mode = 1;
    new_frame(); add(32'h46, 2'b00, 1'b1); add(32'h11); add(32'h22); add(32'h33); add(32'h44);
    run_frame("data4");

    // REG FIS ending early: cmd_* must hold
    rdy_mode = 0;
    new_frame(); add(32'h00258027, 2'b00, 1'b1); add(32'h40123456); add(32'h0);
    run_frame("reg_short");

    // unknown type
    new_frame(); add(32'h0000005F, 2'b00, 1'b1); add(32'hAAAA5555); add(32'h12345678);
    run_frame("unknown");

    // DATA with link error on last payload beat
    rdy_mode = 1;
    new_frame(); add(32'h46, 2'b00, 1'b1); add(32'hA1); add(32'hA2); add(32'hA3, 2'b01);
    run_frame("data_err");

    // zero-length DATA, BIST ok, BIST long, REG with drop, REG long, REG mid-sop
    rdy_mode = 0;
    new_frame(); add(32'h46, 2'b00, 1'b1);
    run_frame("data0");
    new_frame(); add(32'h58, 2'b00, 1'b1); add(32'h1); add(32'h2);
    run_frame("bist_ok");
    new_frame(); add(32'h58, 2'b00, 1'b1); add(32'h1); add(32'h2); add(32'h3); add(32'h4);
    run_frame("bist_long");
    new_frame(); add(32'h00C88027, 2'b00, 1'b1); add(32'h40000010, 2'b10); add(32'h0); add(32'h8); add(32'h0);
    run_frame("reg_drop");
    new_frame(); add(32'h00C88027, 2'b00, 1'b1); add(32'h1); add(32'h2); add(32'h3); add(32'h4); add(32'h5);
    run_frame("reg_long");
    new_frame(); add(32'h00308027, 2'b00, 1'b1); add(32'h1, 2'b00, 1'b1); add(32'h2); add(32'h3); add(32'h4);
    run_frame("reg_midsop");

    // stray beat without sop in IDLE
    new_frame(); add(32'hDEAD0027, 2'b00, 1'b0);
    run_frame("nosop");

    // oversize DATA
    new_frame(); add(32'h46, 2'b00, 1'b1);
    for (int k = 0; k < MAXD + 5; k++) add(32'h10000 + k);
    run_frame("data_over");

    // asynchronous reset with a payload beat held in the output slice
    rdy_mode = 3;
    repeat (2) @(negedge clk);
    new_frame(); add(32'h46, 2'b00, 1'b1);
    for (int k = 0; k < 10; k++) add(32'hB0 + k);
    r0 = n_ok + n_err;
    send_limit = 2;
    send_frame();
    send_limit = 1 << 30;
    chk("slice_full", m_axis_tvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mvld", m_axis_tvalid, 1'b0);
    chk("arst_tready", s_axis_tready, 1'b0);
    chk("arst_cmd", cmd_bus, 105'd0);
    m_cmd = '0;
    @(negedge clk); rst = 1'b0; rdy_mode = 0;
    repeat (5) @(negedge clk);
    chk("arst_noresp", n_ok + n_err, r0);
    chk("arst_mvld_after", m_axis_tvalid, 1'b0);
    new_frame(); add(32'h00EC8027, 2'b00, 1'b1); add(32'hE0000000); add(32'h0); add(32'h1); add(32'h0);
    run_frame("post_rst");

    // randomized frames
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int sel, len;
      logic [7:0] ty;
      logic [1:0] eb;
      logic sop;
      logic [31:0] d;
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin ty = 8'h27; len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 5; end
        1: begin ty = 8'h46; len = $urandom_range(1, 12); end
        2: begin ty = 8'h58; len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 3; end
        default: begin
          case ($urandom_range(0, 3))
            0: ty = 8'h5F;
            1: ty = 8'h34;
            2: ty = 8'h00;
            default: ty = 8'hA1;
          endcase
          len = $urandom_range(1, 4);
        end
      endcase
      new_frame();
      for (int i = 0; i < len; i++) begin
        eb  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
        sop = (i == 0) ? 1'b1 : 1'($urandom_range(0, 19) == 0);
        d   = (i == 0) ? {24'($urandom), ty} : 32'($urandom);
        add(d, eb, sop);
      end
      run_frame("rnd");
    end

    chk("both_high", n_both, 0);
    chk("vld_without_ok", n_badvld, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sata_tl_rx_fis_dev.md
Name: sata_tl_rx_fis_dev

Overview:
Device-side transport-layer receive parser. It sits directly downstream of the device link controller's received-frame AXI-Stream output, and drives that controller's tl_ok/tl_err status inputs. It classifies each received FIS, unpacks Host-to-Device Register FIS fields into a command bus, and forwards Data FIS payload (header stripped) on an AXI-Stream output. Malformed or link-errored frames are reported through tl_err.

Parameters:
USER_W, 8, tuser width; layout {drop,err,keep[3:0],sop,eop}, with eop at bit 0
MAX_DATA_DW, 2048, maximum Data FIS payload in dwords
CNT_W, 16, statistics counter width (used only with the optional feature)

Ports:
clk  in  1  single clock domain
rst  in  1  asynchronous, active-high reset
s_axis_tdata  in  32  FIS dwords from link controller
s_axis_tuser  in  USER_W  {drop,err,keep,sop,eop}
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat ready
tl_ok  out  1  one-cycle pulse: last frame accepted
tl_err  out  1  one-cycle pulse: last frame rejected
cmd_vld  out  1  one-cycle pulse: new register FIS fields valid
cmd_c  out  1  command/control bit (DW0[15])
cmd_command  out  8  DW0[23:16]
cmd_features  out  16  {DW2[31:24],DW0[31:24]}
cmd_lba  out  48  {DW2[23:0],DW1[23:0]}
cmd_device  out  8  DW1[31:24]
cmd_count  out  16  DW3[15:0]
cmd_control  out  8  DW3[31:24]
m_axis_tdata  out  32  Data FIS payload
m_axis_tuser  out  USER_W  same layout as input; err set on a failed frame's eop beat
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output beat ready

Behaviour:
- Reset values: all outputs 0, state IDLE, output register empty. s_axis_tready is 0 during reset.
- FIS type is taken from DW0[7:0] of the sop beat:
  - 0x27: REG
  - 0x46: DATA
  - 0x58: BIST (3 dwords; content ignored)
  - any other value: DISCARD with error flag set.
- States: IDLE, REG, DATA, BIST, DISCARD, RESP.
- IDLE: s_axis_tready=1.
  - A beat without sop is dropped silently, with no response.
  - A sop beat with eop is a 1-dword frame and is an error, except for a DATA frame, which is handled as zero-length below.
- REG: capture DW0..DW4 into shadow registers; s_axis_tready=1.
  - eop on DW4 with no error goes to RESP ok.
  - eop before DW4 is an error.
  - No eop on DW4: set the error flag and go to DISCARD until eop.
- BIST: same length rule as REG, with exactly 3 dwords.
- DATA: header dword not forwarded; each subsequent dword is forwarded.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready, i.e. a single output register slice.
  - Forwarded tuser: sop on the first payload dword, eop/keep copied from input.
  - Zero payload (eop on header) is an error; nothing is forwarded.
  - On payload dword MAX_DATA_DW+1: forward it with eop=1, err=1, then go to DISCARD until input eop; final status is error.
- DISCARD: s_axis_tready=1, consume until eop, then go to RESP err.
- Error sources, OR-ed into the frame error flag:
  - input err or drop on any beat
  - unknown type
  - length violation
  - sop seen mid-frame (that beat is treated as ordinary data)
- RESP lasts one cycle with s_axis_tready=0.
  - Exactly one of tl_ok/tl_err is high.
  - cmd_vld pulses with tl_ok for REG frames only.
  - cmd_* fields update from the shadows in that cycle and hold until the next accepted REG FIS.
  - Status latency: 1 cycle after the eop handshake.
- An output beat carrying eop of a frame with any error has tuser err=1.
- tl_ok/tl_err/cmd_vld never assert outside RESP; at most one response per frame.
- Asynchronous reset mid-frame aborts the frame: no response, output slice emptied.

Optional Feature:
- Macro: SATA_TL_RX_STAT_EN.
- Defined: adds outputs stat_ok_cnt[CNT_W-1:0], stat_err_cnt[CNT_W-1:0] and stat_drop_cnt[CNT_W-1:0].
  - stat_ok_cnt and stat_err_cnt increment on tl_ok and tl_err respectively.
  - stat_drop_cnt increments on IDLE beats without sop.
  - All three saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; all other behaviour unchanged.

Decomposition:
- Package sata_tl_pkg holds:
  - FIS type constants (0x27, 0x46, 0x58, and 0x34 reserved for transmit)
  - tuser bit-index localparams
  - packed struct h2d_reg_t for the cmd fields
  - state enum
- Natural sub-module: sata_axis_reg_slice, a one-entry AXI-Stream register for the payload output.

Test Plan:
- REG FIS DW0=0x00EC8027, DW1=0xE0000000, DW2=0, DW3=0x00000001, DW4=0 with eop on DW4 -> tl_ok pulse 1 cycle after eop; cmd_vld=1, cmd_c=1, cmd_command=0xEC, cmd_device=0xE0, cmd_count=1.
- DATA FIS header 0x00000046 + 4 payload dwords 0x11..0x44, m_axis_tready toggling 1/0 -> exactly 4 output beats in order, sop on 0x11, eop on 0x44, err=0; then tl_ok.
- REG FIS with eop on DW2 -> tl_err; cmd_vld stays 0; cmd_* keep previous values.
- Unknown type 0x5F, 3 dwords -> no output beats, tl_err.
- DATA FIS with input err bit set on the last payload beat -> that beat is forwarded with eop=1, err=1; tl_err.
- DATA FIS with MAX_DATA_DW+5 payload dwords -> MAX_DATA_DW+1 beats forwarded, the last with eop=1, err=1; 4 dwords discarded; tl_err. Also assert rst mid-frame -> no pulse, and the next frame is parsed normally.
